// File: rtl/gnss_time_base.sv
// TIC / ACCUM time-base generator: two independent reloading down-counters with zero-count strobes.
// Optional TIME_BASE_ACCUM_SYNC_EN: force-reload the ACCUM counter on every pre-TIC strobe.
module gnss_time_base #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] tic_divide,
    input  logic [WIDTH-1:0] accum_divide,
    output logic             pre_tic_enable,
    output logic             tic_enable,
    output logic             accum_enable,
    output logic             accum_sample_enable,
    output logic [WIDTH-1:0] tic_count,
    output logic [WIDTH-1:0] accum_count
);

    logic [WIDTH-1:0] tic_next;
    logic [WIDTH-1:0] accum_next;

    assign pre_tic_enable = rstn & (tic_count == '0);
    assign accum_enable   = rstn & (accum_count == '0);

    always_comb begin
        tic_next = '0;
        if (tic_count == '0) begin
            tic_next = tic_divide;
        end else begin
            tic_next = tic_count - WIDTH'(1);
        end
    end

    always_comb begin
        accum_next = '0;
`ifdef TIME_BASE_ACCUM_SYNC_EN
        // A TIC epoch re-phases ACCUM; accum_enable still pulses if the count is 0 now.
        if (pre_tic_enable || (accum_count == '0)) begin
            accum_next = accum_divide;
        end else begin
            accum_next = accum_count - WIDTH'(1);
        end
`else
        if (accum_count == '0) begin
            accum_next = accum_divide;
        end else begin
            accum_next = accum_count - WIDTH'(1);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tic_count           <= '0;
            accum_count         <= '0;
            tic_enable          <= 1'b0;
            accum_sample_enable <= 1'b0;
        end else begin
            tic_count           <= tic_next;
            accum_count         <= accum_next;
            tic_enable          <= pre_tic_enable;
            accum_sample_enable <= accum_enable;
        end
    end

endmodule

// File: tb/tb_gnss_time_base.sv
// Bench for gnss_time_base: directed scenarios plus random divisors/resets against a
// model that tracks the absolute cycle of the next strobe for each counter.
module tb_gnss_time_base;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] tic_divide;
    logic [W-1:0] accum_divide;
    logic         pre_tic_enable;
    logic         tic_enable;
    logic         accum_enable;
    logic         accum_sample_enable;
    logic [W-1:0] tic_count;
    logic [W-1:0] accum_count;

    int n_checks = 0;
    int n_fail   = 0;

    longint t        = 0;
    longint tic_due  = 0;
    longint acc_due  = 0;
    bit     prev_pre = 1'b0;
    bit     prev_acc = 1'b0;
    bit     valid    = 1'b0;

    gnss_time_base #(.WIDTH(W)) time_base (
        .clk                 (clk),
        .rstn                (rstn),
        .tic_divide          (tic_divide),
        .accum_divide        (accum_divide),
        .pre_tic_enable      (pre_tic_enable),
        .tic_enable          (tic_enable),
        .accum_enable        (accum_enable),
        .accum_sample_enable (accum_sample_enable),
        .tic_count           (tic_count),
        .accum_count         (accum_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare against model, advance model across the next edge.
    task automatic step(input bit r, input logic [W-1:0] td, input logic [W-1:0] ad);
        longint       dt;
        longint       da;
        bit           e_pre;
        bit           e_acc;
        logic [W-1:0] e_tc;
        logic [W-1:0] e_ac;
        @(negedge clk);
        rstn         = r;
        tic_divide   = td;
        accum_divide = ad;
        #1;
        e_pre = 1'b0;
        e_acc = 1'b0;
        if (valid) begin
            dt    = tic_due - t;
            da    = acc_due - t;
            e_tc  = dt[W-1:0];
            e_ac  = da[W-1:0];
            e_pre = r && (dt == 0);
            e_acc = r && (da == 0);
            check("tic_count", 32'(tic_count), 32'(e_tc));
            check("accum_count", 32'(accum_count), 32'(e_ac));
            check("pre_tic_enable", 32'(pre_tic_enable), 32'(e_pre));
            check("accum_enable", 32'(accum_enable), 32'(e_acc));
            check("tic_enable", 32'(tic_enable), 32'(prev_pre));
            check("accum_sample_enable", 32'(accum_sample_enable), 32'(prev_acc));
        end
        if (!r) begin
            tic_due  = t + 1;
            acc_due  = t + 1;
            prev_pre = 1'b0;
            prev_acc = 1'b0;
            valid    = 1'b1;
        end else if (valid) begin
            if (e_pre) tic_due = t + longint'(td) + 1;
            if (e_acc) acc_due = t + longint'(ad) + 1;
`ifdef TIME_BASE_ACCUM_SYNC_EN
            if (e_pre) acc_due = t + longint'(ad) + 1;
`endif
            prev_pre = e_pre;
            prev_acc = e_acc;
        end
        t++;
    endtask

    initial begin
        logic [W-1:0] td;
        logic [W-1:0] ad;
        int unsigned  len;
        rstn         = 1'b0;
        tic_divide   = W'(255);
        accum_divide = W'(511);

        for (int i = 0; i < 5; i++) step(1'b0, W'(255), W'(511));
        for (int i = 0; i < 4800; i++) step(1'b1, W'(255), W'(511));
        // Divisor change mid-period: running period still completes at 256.
        for (int i = 0; i < 130; i++) step(1'b1, W'(255), W'(511));
        for (int i = 0; i < 700; i++) step(1'b1, W'(99), W'(511));
        for (int i = 0; i < 80; i++) step(1'b1, W'(99), W'(0));
        for (int i = 0; i < 40; i++) step(1'b1, W'(0), W'(7));
        step(1'b0, W'(255), W'(511));
        for (int i = 0; i < 600; i++) step(1'b1, W'(255), W'(511));
        // Largest divisor: reload to all ones and count down.
        step(1'b0, '1, '1);
        for (int i = 0; i < 40; i++) step(1'b1, '1, '1);
        step(1'b0, W'(99), W'(511));
        for (int i = 0; i < 1200; i++) step(1'b1, W'(99), W'(511));

        for (int s = 0; s < 25; s++) begin
            td  = W'($urandom_range(0, 40));
            ad  = W'($urandom_range(0, 60));
            len = $urandom_range(50, 300);
            for (int unsigned i = 0; i < len; i++) begin
                step(($urandom_range(0, 99) != 0), td, ad);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
